// File: rtl/apu_mmio_target.sv
// rtl/apu_mmio_target.sv - audio unit MMIO target: register bank, sample FIFO and rate timer
module apu_mmio_target #(
  parameter logic [7:0] BASE_TAG   = 8'h09,
  parameter int         FIFO_DEPTH = 16,
  parameter int         SAMPLE_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         s_addr,
  input  logic                s_en,
  input  logic                s_we,
  input  logic [31:0]         s_wdata,
  output logic [31:0]         s_rdata,
  output logic                s_rvalid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_strobe,
  output logic                irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_FIFO   = 6'h02;
  localparam logic [5:0] OFF_RATE   = 6'h03;
  localparam logic [5:0] OFF_THRESH = 6'h04;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         level;
  logic [7:0]          level8;
  logic                en, ovf, unf;
  logic [15:0]         rate, cnt;
  logic [7:0]          thresh;

  logic       qual, wr, rd, clr, tick, push_req, push, pop;
  logic       fifo_empty, fifo_full, status_wr, rate_wr;
  logic [5:0] off;
  logic [31:0] rd_mux;
  logic       unused_bits;

  assign qual       = s_en && (s_addr[31:24] == BASE_TAG);
  assign off        = s_addr[7:2];
  assign wr         = qual && s_we;
  assign rd         = qual && !s_we;
  assign clr        = wr && (off == OFF_CTRL) && s_wdata[1];
  assign status_wr  = wr && (off == OFF_STATUS);
  assign rate_wr    = wr && (off == OFF_RATE);
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (PW+1)'(FIFO_DEPTH));
  assign level8     = 8'(level);
  assign tick       = en && (cnt == rate);
  // A clear wins over a tick in the same cycle so sample_out is left untouched.
  assign pop        = tick && !fifo_empty && !clr;
  assign push_req   = wr && (off == OFF_FIFO) && !clr;
  assign push       = push_req && !fifo_full;
  assign unused_bits = ^{s_addr[23:8], s_addr[1:0], s_wdata};

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:   rd_mux[0]     = en;
      OFF_STATUS: rd_mux[11:0]  = {unf, ovf, fifo_full, fifo_empty, level8};
      OFF_RATE:   rd_mux[15:0]  = rate;
      OFF_THRESH: rd_mux[7:0]   = thresh;
      default:    rd_mux        = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_wdata[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_rdata       <= '0;
      s_rvalid      <= 1'b0;
      sample_out    <= '0;
      sample_strobe <= 1'b0;
      irq           <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      en            <= 1'b0;
      ovf           <= 1'b0;
      unf           <= 1'b0;
      rate          <= '0;
      cnt           <= '0;
      thresh        <= '0;
    end else begin
      s_rvalid      <= rd;
      if (rd) s_rdata <= rd_mux;
      sample_strobe <= pop;
      if (pop) sample_out <= mem[rd_ptr];
      irq           <= en && (level8 <= thresh);

      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
      end

      // Sticky flags: setting events take priority over a software clear.
      if (clr)                          ovf <= 1'b0;
      else if (push_req && fifo_full)   ovf <= 1'b1;
      else if (status_wr && s_wdata[10]) ovf <= 1'b0;

      if (clr)                          unf <= 1'b0;
      else if (tick && fifo_empty)      unf <= 1'b1;
      else if (status_wr && s_wdata[11]) unf <= 1'b0;

      if (!en || clr || rate_wr || tick) cnt <= '0;
      else                               cnt <= cnt + 1'b1;

      if (wr && (off == OFF_CTRL))   en     <= s_wdata[0];
      if (rate_wr)                   rate   <= s_wdata[15:0];
      if (wr && (off == OFF_THRESH)) thresh <= s_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_apu_mmio_target.sv
// tb/tb_apu_mmio_target.sv - self-checking bench for apu_mmio_target against a queue-based model
module tb_apu_mmio_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_addr = '0;
  logic        s_en = 1'b0;
  logic        s_we = 1'b0;
  logic [31:0] s_wdata = '0;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic [15:0] sample_out;
  logic        sample_strobe;
  logic        irq;

  apu_mmio_target dut (
    .clk(clk), .rst(rst), .s_addr(s_addr), .s_en(s_en), .s_we(s_we),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .sample_out(sample_out), .sample_strobe(sample_strobe), .irq(irq)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_CTRL   = 32'h0900_0000;
  localparam logic [31:0] A_STATUS = 32'h0900_0004;
  localparam logic [31:0] A_FIFO   = 32'h0900_0008;
  localparam logic [31:0] A_RATE   = 32'h0900_000C;
  localparam logic [31:0] A_THRESH = 32'h0900_0010;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] q[$];
  logic        m_en, m_ovf, m_unf;
  int          m_rate, m_thresh, m_cnt;
  logic [31:0] exp_rdata;
  logic        exp_rvalid, exp_strobe, exp_irq;
  logic [15:0] exp_sample;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int off);
    logic [31:0] v;
    v = 0;
    case (off)
      0:  v = {31'b0, m_en};
      4:  v = (32'(m_unf) << 11) | (32'(m_ovf) << 10) | (32'(q.size() == 16) << 9)
            | (32'(q.size() == 0) << 8) | 32'(q.size());
      12: v = 32'(m_rate);
      16: v = 32'(m_thresh);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic void model_step(input logic r, input logic e, input logic w,
                                     input logic [31:0] a, input logic [31:0] d);
    logic qual, wr, rd, tick, clr, full0;
    int off;
    if (r) begin
      q.delete();
      m_en = 0; m_ovf = 0; m_unf = 0; m_rate = 0; m_thresh = 0; m_cnt = 0;
      exp_rdata = 0; exp_rvalid = 0; exp_strobe = 0; exp_irq = 0; exp_sample = 0;
      return;
    end
    qual  = e && (a[31:24] == 8'h09);
    wr    = qual && w;
    rd    = qual && !w;
    off   = int'(a[7:0]) & 32'hFC;
    tick  = m_en && (m_cnt == m_rate);
    clr   = wr && off == 0 && d[1];
    full0 = (q.size() == 16);
    exp_irq    = m_en && (q.size() <= m_thresh);
    exp_rvalid = rd;
    if (rd) exp_rdata = model_read(off);
    if (wr && off == 4) begin
      if (d[10]) m_ovf = 0;
      if (d[11]) m_unf = 0;
    end
    exp_strobe = 0;
    if (tick && !clr) begin
      if (q.size() > 0) begin
        exp_sample = q.pop_front();
        exp_strobe = 1;
      end else m_unf = 1;
    end
    if (wr && off == 8) begin
      if (full0) m_ovf = 1;
      else q.push_back(d[15:0]);
    end
    if (!m_en || clr || (wr && off == 12) || tick) m_cnt = 0;
    else m_cnt++;
    if (wr && off == 0)  m_en = d[0];
    if (wr && off == 12) m_rate = int'(d[15:0]);
    if (wr && off == 16) m_thresh = int'(d[7:0]);
    if (clr) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end
  endfunction

  task automatic cycle(input logic r, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    rst = r; s_en = e; s_we = w; s_addr = a; s_wdata = d;
    @(posedge clk);
    model_step(r, e, w, a, d);
    #1;
    check("rvalid", {31'b0, s_rvalid}, {31'b0, exp_rvalid});
    check("rdata", s_rdata, exp_rdata);
    check("sample_out", {16'b0, sample_out}, {16'b0, exp_sample});
    check("strobe", {31'b0, sample_strobe}, {31'b0, exp_strobe});
    check("irq", {31'b0, irq}, {31'b0, exp_irq});
  endtask

  task automatic idle();
    cycle(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    cycle(0, 1, 1, a, d);
  endtask

  task automatic rd32(input logic [31:0] a);
    cycle(0, 1, 0, a, 32'h0);
  endtask

  initial begin
    int first_t, second_t, nstrobe;
    logic [15:0] s1, s2;
    logic seen;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("reset_outputs", {s_rdata[0], s_rvalid, sample_strobe, irq, sample_out}, 20'h0);
    rd32(A_STATUS);
    check("reset_status_rvalid", {31'b0, s_rvalid}, 32'h1);
    check("reset_status", s_rdata, 32'h0000_0100);

    // Two samples drained at RATE=3, then underflow
    wr32(A_RATE, 3);
    wr32(A_FIFO, 32'h1111);
    wr32(A_FIFO, 32'h2222);
    wr32(A_CTRL, 1);
    nstrobe = 0; first_t = 0; second_t = 0; s1 = 0; s2 = 0;
    for (int i = 1; i <= 14; i++) begin
      idle();
      if (sample_strobe) begin
        nstrobe++;
        if (nstrobe == 1) begin first_t = i; s1 = sample_out; end
        if (nstrobe == 2) begin second_t = i; s2 = sample_out; end
      end
    end
    check("rate_strobe_count", nstrobe, 2);
    check("rate_first_tick", first_t, 4);
    check("rate_gap", second_t - first_t, 4);
    check("rate_sample1", {16'b0, s1}, 32'h1111);
    check("rate_sample2", {16'b0, s2}, 32'h2222);
    rd32(A_STATUS);
    check("unf_status", s_rdata & 32'h0000_0F1F, 32'h0000_0900);
    check("unf_sample_held", {16'b0, sample_out}, 32'h2222);

    // Overflow with EN=0
    wr32(A_CTRL, 2);
    for (int i = 0; i < 17; i++) wr32(A_FIFO, 32'h100 + i);
    rd32(A_STATUS);
    check("ovf_status", s_rdata, 32'h0000_0610);
    wr32(A_STATUS, 32'h400);
    rd32(A_STATUS);
    check("ovf_cleared", s_rdata, 32'h0000_0210);

    // RATE=0: push coinciding with a pop leaves the level unchanged
    wr32(A_CTRL, 2);
    wr32(A_RATE, 0);
    wr32(A_FIFO, 32'hAAAA);
    wr32(A_CTRL, 1);
    wr32(A_FIFO, 32'hBBBB);
    check("same_cycle_strobe", {31'b0, sample_strobe}, 32'h1);
    check("same_cycle_old_head", {16'b0, sample_out}, 32'hAAAA);
    rd32(A_STATUS);
    check("same_cycle_level", {24'b0, s_rdata[7:0]}, 32'h1);
    wr32(A_CTRL, 0);

    // Low-water irq
    wr32(A_CTRL, 2);
    wr32(A_THRESH, 2);
    wr32(A_RATE, 9);
    for (int i = 0; i < 3; i++) wr32(A_FIFO, 32'h50 + i);
    wr32(A_CTRL, 1);
    idle();
    check("irq_above_thresh", {31'b0, irq}, 32'h0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle();
      if (sample_strobe) seen = 1;
    end
    check("irq_pop_seen", {31'b0, seen}, 32'h1);
    check("irq_same_cycle", {31'b0, irq}, 32'h0);
    idle();
    check("irq_after_pop", {31'b0, irq}, 32'h1);

    // Foreign tag ignored, then CLR
    wr32(A_CTRL, 2);
    for (int i = 0; i < 5; i++) wr32(A_FIFO, 32'h70 + i);
    wr32(32'h0600_0008, 32'h1234);
    rd32(A_STATUS);
    check("foreign_tag_level", s_rdata, 32'h0000_0005);
    wr32(A_CTRL, 2);
    rd32(A_STATUS);
    check("clr_status", s_rdata, 32'h0000_0100);

    // Reset during a read
    wr32(A_THRESH, 5);
    wr32(A_CTRL, 1);
    cycle(1, 1, 0, A_STATUS, 0);
    check("rst_rvalid", {31'b0, s_rvalid}, 32'h0);
    check("rst_outputs", {s_rdata, 1'b0, sample_strobe, irq, sample_out}, 51'h0);
    idle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [31:0] a, d;
      logic [7:0] tag;
      k = int'($urandom_range(0, 99));
      tag = ($urandom_range(0, 9) == 0) ? 8'h0A : 8'h09;
      d = $urandom;
      case ($urandom_range(0, 6))
        0: a = A_CTRL;
        1: a = A_STATUS;
        2, 3: a = A_FIFO;
        4: a = A_RATE;
        5: a = A_THRESH;
        default: a = 32'h0900_0040 | 32'($urandom_range(0, 3));
      endcase
      a[31:24] = tag;
      if (a[7:0] == 8'h00) d[1] = ($urandom_range(0, 7) == 0);
      if (a[7:0] == 8'h0C) d = 32'($urandom_range(0, 4));
      if (a[7:0] == 8'h10) d = 32'($urandom_range(0, 20));
      if (k == 0)       cycle(1, 0, 0, 0, 0);
      else if (k < 40)  idle();
      else              cycle(0, 1, $urandom_range(0, 1) == 1, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
